// File: rtl/duck_palette_arbiter.sv
// Chooses the highest-priority opaque duck layer for each pixel, looks up its colour in the
// external palette, and registers the result. Also runs the per-layer hit-flash counters.
module duck_palette_arbiter #(
  parameter int NUM_LAYERS      = 4,
  parameter int TRANSPARENT_IDX = 1,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [4*NUM_LAYERS-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic [11:0]             bg_rgb,
  input  logic [NUM_LAYERS-1:0]   hit,
  output logic [3:0]              pal_index,
  input  logic [11:0]             pal_rgb,
  output logic                    out_valid,
  output logic [11:0]             out_rgb,
  output logic [NUM_LAYERS-1:0]   flashing
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [3:0] T_IDX   = 4'(TRANSPARENT_IDX);
  localparam logic [3:0] F_LOAD  = 4'(FLASH_FRAMES);

  logic [NUM_LAYERS-1:0] w_opaque;
  logic                  w_win_found;
  logic [LW-1:0]         w_win_layer;
  logic [3:0]            w_win_idx;
  logic                  w_flash_white;

  logic                  r_s1_valid;
  logic                  r_s1_opaque;
  logic [LW-1:0]         r_s1_layer;
  logic [11:0]           r_s1_bg;
  logic [3:0]            r_pal_index;
  logic                  r_out_valid;
  logic [11:0]           r_out_rgb;
  logic                  r_phase;
  logic [3:0]            r_flash_cnt [NUM_LAYERS];

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_opaque[k] = layer_en[k] && (layer_idx[4*k +: 4] != T_IDX);
    end
  end

  // Scan from the lowest priority upward so the lowest-numbered opaque layer overwrites the rest.
  always_comb begin
    w_win_found = 1'b0;
    w_win_layer = '0;
    w_win_idx   = T_IDX;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (w_opaque[k]) begin
        w_win_found = 1'b1;
        w_win_layer = LW'(k);
        w_win_idx   = layer_idx[4*k +: 4];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_opaque <= 1'b0;
      r_s1_layer  <= '0;
      r_s1_bg     <= 12'h000;
      r_pal_index <= T_IDX;
    end else begin
      r_s1_valid  <= pix_valid;
      r_s1_opaque <= w_win_found;
      r_s1_layer  <= w_win_layer;
      r_s1_bg     <= bg_rgb;
      r_pal_index <= w_win_idx;
    end
  end

  assign w_flash_white = r_s1_opaque && (r_flash_cnt[r_s1_layer] != 4'd0) && r_phase;

  // Palette is combinational, so pal_rgb already answers the index held in stage 1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out_rgb   <= 12'h000;
    end else begin
      r_out_valid <= r_s1_valid;
      if (w_flash_white) begin
        r_out_rgb <= 12'hFFF;
      end else if (r_s1_opaque) begin
        r_out_rgb <= pal_rgb;
      end else begin
        r_out_rgb <= r_s1_bg;
      end
    end
  end

  // A hit reload takes precedence over the frame decrement in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_phase <= 1'b0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_flash_cnt[k] <= 4'd0;
      end
    end else begin
      if (frame_start) begin
        r_phase <= ~r_phase;
      end
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (hit[k]) begin
          r_flash_cnt[k] <= F_LOAD;
        end else if (frame_start && (r_flash_cnt[k] != 4'd0)) begin
          r_flash_cnt[k] <= r_flash_cnt[k] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      flashing[k] = (r_flash_cnt[k] != 4'd0);
    end
  end

  assign pal_index = r_pal_index;
  assign out_valid = r_out_valid;
  assign out_rgb   = r_out_rgb;

endmodule

// File: tb/tb_duck_palette_arbiter.sv
// Directed bench for duck_palette_arbiter: priority/transparency, latency, flash sequencing, reset.
module tb_duck_palette_arbiter;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] layer_idx;
  logic [3:0]  layer_en;
  logic [11:0] bg_rgb;
  logic [3:0]  hit;
  logic [3:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        out_valid;
  logic [11:0] out_rgb;
  logic [3:0]  flashing;

  int total;
  int bad;

  duck_palette_arbiter #(
    .NUM_LAYERS(4),
    .TRANSPARENT_IDX(1),
    .FLASH_FRAMES(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .layer_idx(layer_idx),
    .layer_en(layer_en),
    .bg_rgb(bg_rgb),
    .hit(hit),
    .pal_index(pal_index),
    .pal_rgb(pal_rgb),
    .out_valid(out_valid),
    .out_rgb(out_rgb),
    .flashing(flashing)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // external palette model
  always_comb begin
    case (pal_index)
      4'd2:    pal_rgb = 12'hA01;
      4'd3:    pal_rgb = 12'h000;
      4'd4:    pal_rgb = 12'hF76;
      default: pal_rgb = 12'h0E0;
    endcase
  end

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pix(input logic [3:0] en, input logic [15:0] idx, input logic [11:0] bg);
    pix_valid = 1'b1;
    layer_en  = en;
    layer_idx = idx;
    bg_rgb    = bg;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    Reset = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    layer_idx = 16'h1111;
    layer_en = 4'b0000;
    bg_rgb = 12'h000;
    hit = 4'b0000;
    tick();
    tick();
    check_val("rst_pal_index", 12'(pal_index), 12'h001);
    check_val("rst_out_valid", 12'(out_valid), 12'h000);
    check_val("rst_out_rgb", out_rgb, 12'h000);
    check_val("rst_flashing", 12'(flashing), 12'h000);
    Reset = 1'b0;
    tick();

    // single layer, two-cycle latency
    set_pix(4'b0001, 16'h1114, 12'h123);
    tick();
    check_val("single_pal_index_n1", 12'(pal_index), 12'h004);
    check_val("single_out_valid_n1", 12'(out_valid), 12'h000);
    set_pix(4'b0000, 16'h2222, 12'h3C3);
    tick();
    check_val("single_out_rgb_n2", out_rgb, 12'hF76);
    check_val("single_out_valid_n2", 12'(out_valid), 12'h001);
    pix_valid = 1'b0;
    tick();
    check_val("no_layer_bg", out_rgb, 12'h3C3);
    tick();
    check_val("invalid_out_valid", 12'(out_valid), 12'h000);

    // priority and transparency
    set_pix(4'b0011, 16'h1121, 12'h777);
    tick();
    check_val("prio_pal_index", 12'(pal_index), 12'h002);
    tick();
    check_val("prio_layer1_wins", out_rgb, 12'hA01);
    set_pix(4'b0011, 16'h1123, 12'h777);
    tick();
    tick();
    check_val("prio_layer0_wins", out_rgb, 12'h000);
    set_pix(4'b0100, 16'h1412, 12'h777);
    tick();
    tick();
    check_val("prio_disabled_layer0", out_rgb, 12'hF76);
    set_pix(4'b1111, 16'h1111, 12'h5AF);
    tick();
    check_val("alltrans_pal_index", 12'(pal_index), 12'h001);
    tick();
    check_val("alltrans_bg", out_rgb, 12'h5AF);

    // hit flash on layer 0 across 16 frames
    set_pix(4'b0001, 16'h1112, 12'h000);
    hit = 4'b0001;
    tick();
    hit = 4'b0000;
    check_val("flash_start", 12'(flashing), 12'h001);
    tick();
    tick();
    check_val("flash_phase0_colour", out_rgb, 12'hA01);
    for (int f = 1; f <= 16; f++) begin
      logic [11:0] exp_rgb;
      logic [3:0]  exp_fl;
      exp_fl  = (f < 8) ? 4'b0001 : 4'b0000;
      exp_rgb = ((f < 8) && (f % 2 == 1)) ? 12'hFFF : 12'hA01;
      pulse_frame();
      tick();
      tick();
      check_val($sformatf("flash_frame%0d_rgb", f), out_rgb, exp_rgb);
      check_val($sformatf("flash_frame%0d_flag", f), 12'(flashing), 12'(exp_fl));
    end

    // layer 2: bring count to 3, then hit together with frame_start -> reload to 8
    hit = 4'b0100;
    tick();
    hit = 4'b0000;
    for (int f = 0; f < 5; f++) pulse_frame();
    check_val("cnt3_still_flashing", 12'(flashing), 12'h004);
    hit = 4'b0100;
    frame_start = 1'b1;
    tick();
    hit = 4'b0000;
    frame_start = 1'b0;
    for (int f = 0; f < 7; f++) pulse_frame();
    check_val("reload_after7", 12'(flashing), 12'h004);
    pulse_frame();
    check_val("reload_after8", 12'(flashing), 12'h000);

    // layer 1: re-hit mid-flash restarts at 8
    hit = 4'b0010;
    tick();
    hit = 4'b0000;
    for (int f = 0; f < 4; f++) pulse_frame();
    hit = 4'b0010;
    tick();
    hit = 4'b0000;
    for (int f = 0; f < 7; f++) pulse_frame();
    check_val("rehit_after7", 12'(flashing), 12'h002);
    pulse_frame();
    check_val("rehit_after8", 12'(flashing), 12'h000);

    // reset during a flash on layer 0 (phase is 0 here; one frame makes it 1)
    set_pix(4'b0001, 16'h1112, 12'h000);
    hit = 4'b0001;
    tick();
    hit = 4'b0000;
    pulse_frame();
    tick();
    tick();
    check_val("pre_reset_flash", out_rgb, 12'hFFF);
    check_val("pre_reset_valid", 12'(out_valid), 12'h001);
    #2;
    Reset = 1'b1;
    #1;
    check_val("reset_async_valid", 12'(out_valid), 12'h000);
    check_val("reset_async_flashing", 12'(flashing), 12'h000);
    tick();
    Reset = 1'b0;
    tick();
    check_val("post_reset_n1_valid", 12'(out_valid), 12'h000);
    tick();
    check_val("post_reset_n2_valid", 12'(out_valid), 12'h001);
    check_val("post_reset_unflashed", out_rgb, 12'hA01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duck_palette_arbiter.md
# duck_palette_arbiter

Shares the single 16-entry duck sprite palette between up to NUM_LAYERS overlapping duck sprite layers in the pixel pipeline. Each pixel, it picks the highest-priority opaque layer, drives that layer's 4-bit index into the palette, and registers the returned 12-bit RGB. It falls back to the background colour when no layer is opaque. It also runs a per-layer, frame-counted "hit flash" sequencer. The block sits between the sprite address/ROM stage and the VGA colour output.

## Interface
Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has the highest priority.
- TRANSPARENT_IDX, 1, palette index treated as transparent.
- FLASH_FRAMES, 8, frames a layer flashes after a hit (1..15).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- pix_valid  in  1  layer_idx/layer_en/bg_rgb valid this cycle.
- layer_idx  in  4*NUM_LAYERS  packed indices; bits [4k+3:4k] belong to layer k.
- layer_en  in  NUM_LAYERS  layer k covers the current pixel.
- bg_rgb  in  12  background colour {R,G,B}.
- hit  in  NUM_LAYERS  one-cycle pulse; starts the flash on layer k.
- pal_index  out  4  index to the palette.
- pal_rgb  in  12  combinational palette return for pal_index.
- out_valid  out  1  out_rgb valid.
- out_rgb  out  12  final pixel colour.
- flashing  out  NUM_LAYERS  layer k flash counter is nonzero.

## Operation
- Layer k is opaque when layer_en[k]=1 and layer_idx[k] != TRANSPARENT_IDX. The winner is the lowest-numbered opaque layer.
- Stage 1 registers, on every cycle, the following values:
  - s1_valid is set from pix_valid.
  - pal_index takes the winner's index, or TRANSPARENT_IDX if there is no winner.
  - s1_opaque is set to 1 when a winner exists.
  - s1_layer takes the winner's number.
  - s1_bg takes bg_rgb.
- Stage 2 registers, on every cycle, the following values:
  - out_valid is set from s1_valid.
  - out_rgb is selected in this order:
    - 12'hFFF when s1_opaque=1, flash_cnt[s1_layer] != 0, and phase=1.
    - Otherwise pal_rgb when s1_opaque=1.
    - Otherwise s1_bg.
- Stages 1 and 2 load regardless of pix_valid, and the valid bit tracks alongside. There is no backpressure.
- Flash sequencer:
  - Each layer has a 4-bit flash_cnt[k].
  - A global phase bit toggles on every frame_start.
  - hit[k] loads FLASH_FRAMES into flash_cnt[k]. A hit while already flashing reloads the counter.
  - When there is no hit, frame_start decrements flash_cnt[k] if it is nonzero. The counter saturates at 0.
  - When hit[k] and frame_start arrive in the same cycle, the reload wins and no decrement happens.
  - flashing[k] = (flash_cnt[k] != 0), driven combinationally from the register.
- pal_index is the only palette access. The palette itself is outside this block.

## Timing
- Reset values: pal_index=TRANSPARENT_IDX, out_valid=0, out_rgb=12'h000, flashing=0, all flash_cnt=0, phase=0, s1_valid=0, s1_opaque=0.
- Latency is 2 cycles. A pixel presented at cycle N appears on out_rgb/out_valid at cycle N+2.
- Throughput is 1 pixel per cycle.
- pal_rgb is sampled in the same cycle that pal_index is registered-valid. The palette is combinational, so there is a zero-cycle lookup inside stage 2.
- flash_cnt and phase update on the Clk edge at which frame_start=1. Pixels already in stage 1 at that edge use the new values in stage 2.
- If Reset asserts mid-frame, the pipeline is dropped: out_valid=0 immediately (asynchronous). The first valid output after Reset deasserts is 2 cycles after the next pix_valid.

## Test plan
- Single layer: layer_en=0001, layer_idx[0]=4, palette idx4=F76, pix_valid=1 -> pal_index=4 at N+1; out_rgb=12'hF76, out_valid=1 at N+2.
- Priority and transparency:
  - layer_en=0011, idx[0]=1 (transparent), idx[1]=2 -> out_rgb=12'hA01 (layer 1 wins).
  - Same with idx[0]=3 -> out_rgb=12'h000.
- All transparent: layer_en=1111, all idx=1, bg_rgb=12'h5AF -> pal_index=1; out_rgb=12'h5AF.
- Hit flash:
  - Pulse hit[0], then 16 frame_start pulses, holding layer 0 opaque with idx=2.
  - out_rgb alternates between 12'hFFF (phase=1) and 12'hA01 on successive frames.
  - flashing[0] drops after the 8th frame_start, and out_rgb stays 12'hA01 from then on.
- Hit on the same cycle as frame_start with flash_cnt[2]=3 -> flash_cnt[2]=8 (reload, no decrement). Re-hit mid-flash restarts the count at 8.
- Reset asserted between pixels during a flash -> out_valid=0 and flashing=0 immediately. The next pixel after deassertion shows its unflashed palette colour 2 cycles later.
